// File: rtl/s2p_rx_if.sv
// Serial-in / parallel-out handshake bundle for s2p_rx.
// The slave side is the converter; the master side is whoever feeds serial
// bits and consumes the assembled words.
interface s2p_rx_if #(
    parameter int N = 4
);
    logic         ser_valid;
    logic         ser_data;
    logic         ser_ready;
    logic [N-1:0] par_data;
    logic         par_valid;
    logic         par_ready;

    modport master (
        output ser_valid,
        output ser_data,
        output par_ready,
        input  ser_ready,
        input  par_data,
        input  par_valid
    );

    modport slave (
        input  ser_valid,
        input  ser_data,
        input  par_ready,
        output ser_ready,
        output par_data,
        output par_valid
    );
endinterface

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver.
// Bits arrive LSB first and are assembled in a shift register. A finished
// word moves into an output register that has its own valid flag. If the
// output register is still occupied when a word completes, the word stays
// parked in the shift register (FULL) and serial input is stalled until the
// output register is drained.
module s2p_rx #(
    parameter int N = 4
) (
    input  logic     clk,
    input  logic     rst,
    s2p_rx_if.slave  bus
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        COLLECT,
        FULL
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  out_q;
    logic          out_valid;

    logic          accept;
    logic          par_xfer;
    logic          last_bit;
    logic [N-1:0]  word_done;
    logic          load_from_ser;
    logic          load_from_hold;

    // ser_ready depends on state alone, so it never forms a path from inputs.
    assign bus.ser_ready = (state == COLLECT);
    assign bus.par_data  = out_q;
    assign bus.par_valid = out_valid;

    assign accept    = bus.ser_valid && (state == COLLECT);
    assign par_xfer  = out_valid && bus.par_ready;
    assign last_bit  = accept && (cnt == LAST);
    // The newest bit enters at the top, so after N shifts bit k sits at index k.
    assign word_done = {bus.ser_data, shift_q[N-1:1]};

    // Next-state and output-register load decisions.
    always_comb begin
        state_next     = state;
        load_from_ser  = 1'b0;
        load_from_hold = 1'b0;
        case (state)
            COLLECT: begin
                if (last_bit) begin
                    if (!out_valid || par_xfer) begin
                        load_from_ser = 1'b1;
                    end else begin
                        state_next = FULL;
                    end
                end
            end
            FULL: begin
                if (par_xfer) begin
                    load_from_hold = 1'b1;
                    state_next     = COLLECT;
                end
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Bit counter: advances per accepted bit and wraps after the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shift register; it freezes in FULL because no bits are accepted there.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (accept) begin
            shift_q <= word_done;
        end
    end

    // Output register: loads a fresh or parked word, or empties on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_valid <= 1'b0;
        end else if (load_from_ser) begin
            out_q     <= word_done;
            out_valid <= 1'b1;
        end else if (load_from_hold) begin
            out_q     <= shift_q;
            out_valid <= 1'b1;
        end else if (par_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/s2p_rx.md
S2P_RX -- requirements
Module: s2p_rx

Interface
REQ-001 Parameter: N, default 4, parallel word width in bits; N >= 2.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ser_valid  input  1  serial bit on ser_data is valid.
REQ-005 ser_data  input  1  serial data bit, LSB of each word first.
REQ-006 ser_ready  output  1  block can accept a serial bit this cycle.
REQ-007 par_data  output  N  assembled parallel word.
REQ-008 par_valid  output  1  par_data holds a complete word.
REQ-009 par_ready  input  1  downstream accepts par_data this cycle.

Function
REQ-010 The block SHALL accept a serial bit only on a rising edge where ser_valid && ser_ready; a par transfer SHALL occur only on a rising edge where par_valid && par_ready.
REQ-011 The k-th accepted bit of a word (k = 0..N-1) SHALL land in bit k of the delivered word.
REQ-012 The bit counter SHALL be $clog2(N) bits wide, SHALL increment by 1 per accepted bit, SHALL wrap to 0 after bit N-1, and SHALL hold when no bit is accepted.
REQ-013 Storage SHALL be a shift register (word being assembled) plus an output register with its own valid flag driving par_data/par_valid.
REQ-014 State machine SHALL have two states: COLLECT (assembling) and FULL (complete word parked in shift register, waiting for the output register).
REQ-015 ser_ready SHALL be 1 in COLLECT and 0 in FULL, decoded from state only, with no combinational path from any input.
REQ-016 On acceptance of bit N-1 in COLLECT, if the output register is empty or transfers on the same edge, the completed word SHALL load into the output register on that edge. par_valid SHALL be 1 in the next cycle and the state SHALL remain COLLECT.
REQ-017 On acceptance of bit N-1 in COLLECT with the output register occupied and not transferring, the state SHALL go to FULL with the word held in the shift register.
REQ-018 In FULL, on a par transfer edge, the shift-register word SHALL load into the output register, par_valid SHALL stay 1, the state SHALL go to COLLECT, and the counter SHALL be 0.
REQ-019 A par transfer with no new word loading on the same edge SHALL clear par_valid on that edge.
REQ-020 par_data SHALL remain stable while par_valid && !par_ready.
REQ-021 Latency SHALL be one cycle from the edge that accepts bit N-1 to par_valid = 1, when the output register is free.
REQ-022 With ser_valid and par_ready held at 1, throughput SHALL be one word per N cycles, with ser_ready never deasserting.
REQ-023 ser_valid low SHALL leave the shift register, counter, and state unchanged.
REQ-024 par_ready asserted while par_valid = 0 SHALL have no effect.

Reset
REQ-025 While rst = 1 at a rising edge, the block SHALL set state = COLLECT, counter = 0, shift register = 0, output register = 0, and par_valid = 0.
REQ-026 The cycle after reset, outputs SHALL be ser_ready = 1, par_valid = 0, par_data = 0.
REQ-027 Reset mid-word or while in FULL SHALL discard all partial and held data; the next N accepted bits SHALL form a fresh word.
REQ-028 Reset SHALL take priority over any simultaneous serial or parallel transfer.

Verification
REQ-029 N=4, par_ready=1; after reset, send bits 1,0,1,1 on consecutive cycles -> par_valid=1 for exactly one cycle, one cycle after the 4th bit, with par_data=4'hD.
REQ-030 N=4, ser_valid=1 continuously, par_ready=1; send word 0x5 then word 0xC -> par_valid pulses every 4 cycles, carrying 0x5 then 0xC; ser_ready stays 1 throughout.
REQ-031 N=4, par_ready=0; send 0x3 then 0xA -> par_data holds 0x3 and ser_ready=0 after 0xA completes; assert par_ready for one cycle -> 0x3 transfers, par_data=0xA the next cycle with par_valid=1, ser_ready=1.
REQ-032 N=4; send bits of 0x6 with one or more ser_valid=0 idle cycles between every bit -> par_data=0x6 and the counter never advances on idle cycles.
REQ-033 N=4; send 2 bits, pulse rst, then send 0x9 -> par_valid stays 0 until 0x9 completes, then par_data=0x9.
REQ-034 N=4, par_ready=0; fill to FULL, then assert rst -> par_valid=0 and ser_ready=1 the next cycle, with no stale word delivered afterwards.
